// File: rtl/cpu_controller_if.sv
// Handshake and datapath-control bundle between the CPU top and cpu_controller.
// The master drives the instruction side; the slave (controller) drives controls.
interface cpu_controller_if #(
    parameter int IW = 16,
    parameter int RW = 3
);
    logic [IW-1:0] in;
    logic          load;
    logic          s;
    logic          w;
    logic [RW-1:0] readnum;
    logic [RW-1:0] writenum;
    logic          write;
    logic          vsel;
    logic          loada;
    logic          loadb;
    logic          loadc;
    logic          loads;
    logic          asel;
    logic          bsel;
    logic [1:0]    shift;
    logic [1:0]    ALUop;
    logic [IW-1:0] datapath_in;
    logic          err;

    modport master (
        output in, load, s,
        input  w, readnum, writenum, write, vsel,
        input  loada, loadb, loadc, loads, asel, bsel,
        input  shift, ALUop, datapath_in, err
    );

    modport slave (
        input  in, load, s,
        output w, readnum, writenum, write, vsel,
        output loada, loadb, loadc, loads, asel, bsel,
        output shift, ALUop, datapath_in, err
    );
endinterface

// File: rtl/cpu_controller.sv
// Instruction register, decoder and Moore sequencer for the 16-bit datapath.
// Optional CPU_CTRL_ILLEGAL_TRAP_EN: illegal instructions set err and halt.
module cpu_controller #(
    parameter int IW = 16,
    parameter int RW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    cpu_controller_if.slave   bus
);

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_WRITE_IMM = 3'd2,
        S_GET_A     = 3'd3,
        S_GET_B     = 3'd4,
        S_ALU       = 3'd5,
        S_WRITE_REG = 3'd6
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
        ,
        S_HALT      = 3'd7
`endif
    } state_e;

    state_e        state_q;
    state_e        state_d;
    logic [IW-1:0] ir_q;
    logic [IW-1:0] ir_d;

    logic [2:0]    opcode;
    logic [1:0]    op;
    logic [RW-1:0] rn;
    logic [RW-1:0] rd;
    logic [RW-1:0] rm;
    logic [1:0]    sh;

    logic          is_mov_imm;
    logic          is_mov_reg;
    logic          is_alu;
    logic          is_cmp;
    logic          is_mvn;
    logic          is_two_op;

    assign opcode = ir_q[15:13];
    assign op     = ir_q[12:11];
    assign rn     = ir_q[10:8];
    assign rd     = ir_q[7:5];
    assign sh     = ir_q[4:3];
    assign rm     = ir_q[2:0];

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu     = (opcode == 3'b101);
    assign is_cmp     = is_alu && (op == 2'b01);
    assign is_mvn     = is_alu && (op == 2'b11);
    assign is_two_op  = is_alu && !is_mvn;

    // IR captures on load regardless of state
    assign ir_d = bus.load ? bus.in : ir_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_WAIT;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    logic err_q;
    logic err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            S_WAIT: begin
                if (bus.s) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                unique case (1'b1)
                    is_mov_imm:            state_d = S_WRITE_IMM;
                    is_mov_reg || is_mvn:  state_d = S_GET_B;
                    is_two_op:             state_d = S_GET_A;
                    default: begin
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
                        state_d = S_HALT;
                        err_d   = 1'b1;
`else
                        state_d = S_WAIT;
`endif
                    end
                endcase
            end
            S_WRITE_IMM: state_d = S_WAIT;
            S_GET_A:     state_d = S_GET_B;
            S_GET_B:     state_d = S_ALU;
            S_ALU: begin
                state_d = is_cmp ? S_WAIT : S_WRITE_REG;
            end
            S_WRITE_REG: state_d = S_WAIT;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
            S_HALT:      state_d = S_HALT;
`endif
            default:     state_d = S_WAIT;
        endcase
    end

    logic          w_o;
    logic [RW-1:0] readnum_o;
    logic [RW-1:0] writenum_o;
    logic          write_o;
    logic          vsel_o;
    logic          loada_o;
    logic          loadb_o;
    logic          loadc_o;
    logic          loads_o;
    logic          asel_o;
    logic [1:0]    shift_o;
    logic [1:0]    aluop_o;

    always_comb begin
        w_o        = 1'b0;
        readnum_o  = '0;
        writenum_o = '0;
        write_o    = 1'b0;
        vsel_o     = 1'b0;
        loada_o    = 1'b0;
        loadb_o    = 1'b0;
        loadc_o    = 1'b0;
        loads_o    = 1'b0;
        asel_o     = 1'b0;
        shift_o    = 2'b00;
        aluop_o    = 2'b00;
        unique case (state_q)
            S_WAIT: w_o = 1'b1;
            S_WRITE_IMM: begin
                writenum_o = rn;
                write_o    = 1'b1;
            end
            S_GET_A: begin
                readnum_o = rn;
                loada_o   = 1'b1;
            end
            S_GET_B: begin
                readnum_o = rm;
                loadb_o   = 1'b1;
            end
            S_ALU: begin
                shift_o = sh;
                aluop_o = is_alu ? op : 2'b00;
                asel_o  = is_mov_reg || is_mvn;
                loads_o = is_cmp;
                loadc_o = !is_cmp;
            end
            S_WRITE_REG: begin
                writenum_o = rd;
                write_o    = 1'b1;
                vsel_o     = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.w           = w_o;
    assign bus.readnum     = readnum_o;
    assign bus.writenum    = writenum_o;
    assign bus.write       = write_o;
    assign bus.vsel        = vsel_o;
    assign bus.loada       = loada_o;
    assign bus.loadb       = loadb_o;
    assign bus.loadc       = loadc_o;
    assign bus.loads       = loads_o;
    assign bus.asel        = asel_o;
    // No imm5 forms exist yet
    assign bus.bsel        = 1'b0;
    assign bus.shift       = shift_o;
    assign bus.ALUop       = aluop_o;
    assign bus.datapath_in = {{(IW-8){ir_q[7]}}, ir_q[7:0]};

endmodule
